// File: rtl/framebuffer_readback_pkg.sv
// framebuffer_readback_pkg: framing constants, FSM encoding and row-digit helpers for the row readback path
package framebuffer_readback_pkg;

    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [3:0] {
        IDLE,
        SEND_HDR,
        SEND_TENS,
        SEND_UNITS,
        FETCH,
        CAPTURE,
        SEND_DATA,
        SEND_TERM,
        FINISH
    } state_t;

    // rows only reach 31, so the tens digit is a three-way compare rather than a divider
    function automatic logic [7:0] tens_ascii(input logic [4:0] r);
        return ASCII_ZERO + (r >= 5'd30 ? 8'd3 : r >= 5'd20 ? 8'd2 : r >= 5'd10 ? 8'd1 : 8'd0);
    endfunction

    function automatic logic [7:0] units_ascii(input logic [4:0] r);
        return ASCII_ZERO + {3'b000, r} - (tens_ascii(r) - ASCII_ZERO) * 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first transmitter for one byte per load, tx_done in the last stop-bit cycle
module uart_tx_byte #(
    parameter int BAUD_TICKS_WIDTH = 8,
    parameter int BAUD_TICKS       = 192
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [BAUD_TICKS_WIDTH-1:0] LAST_TICK = BAUD_TICKS_WIDTH'(BAUD_TICKS - 1);

    logic [9:0]                  shift_q, shift_d;
    logic [3:0]                  bit_q, bit_d;
    logic [BAUD_TICKS_WIDTH-1:0] baud_q, baud_d;
    logic                        busy_q, busy_d;
    logic                        bit_end;

    // line is forced high whenever no frame is shifting, so an async reset idles it at once
    assign tx_out  = !busy_q || shift_q[0];
    assign tx_busy = busy_q;

    // frame shifter: {stop, data, start} shifted right once per bit period
    always_comb begin
        bit_end = busy_q && baud_q == LAST_TICK;
        tx_done = bit_end && bit_q == 4'd9;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        busy_d  = busy_q;
        if (load && !busy_q) begin
            shift_d = {1'b1, data, 1'b0};
            bit_d   = '0;
            baud_d  = '0;
            busy_d  = 1'b1;
        end else if (bit_end) begin
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 1'b1;
            baud_d  = '0;
            busy_d  = !tx_done;
        end else if (busy_q) begin
            baud_d  = baud_q + 1'b1;
        end
    end

    // transmitter state registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift_q <= '1;
            bit_q   <= '0;
            baud_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/framebuffer_readback.sv
// framebuffer_readback: reads one framebuffer row from RAM port A and sends it as 'L', row digits, 128 bytes, '\n'
module framebuffer_readback
    import framebuffer_readback_pkg::*;
#(
    parameter int BAUD_TICKS_WIDTH = 8,
    parameter int BAUD_TICKS       = 192,
    parameter int ROW_BYTES_LOG2   = 7
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      start,
    input  logic [4:0]                row,
    output logic [ROW_BYTES_LOG2+4:0] ram_address,
    output logic                      ram_clk_enable,
    input  logic [7:0]                ram_data_in,
    output logic                      busy,
    output logic                      done,
    output logic                      tx_out
);

    localparam logic [ROW_BYTES_LOG2-1:0] LAST_IDX = '1;

    state_t                    state_q, state_d;
    logic [4:0]                row_q, row_d;
    logic [ROW_BYTES_LOG2-1:0] idx_q, idx_d;
    logic [7:0]                byte_q, byte_d;
    logic [ROW_BYTES_LOG2+4:0] addr_q, addr_d;
    logic                      tx_load, tx_busy, tx_done;
    logic [7:0]                tx_data;

    assign busy           = !(state_q inside {IDLE, FINISH});
    assign done           = state_q == FINISH;
    assign ram_clk_enable = state_q == FETCH;
    assign ram_address    = addr_q;

    uart_tx_byte #(
        .BAUD_TICKS_WIDTH(BAUD_TICKS_WIDTH),
        .BAUD_TICKS      (BAUD_TICKS)
    ) u_tx (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (tx_load),
        .data   (tx_data),
        .tx_out (tx_out),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    // sequencer: each SEND_* state loads the transmitter once and advances on its tx_done
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        tx_load = !tx_busy && (state_q inside {SEND_HDR, SEND_TENS, SEND_UNITS, SEND_DATA, SEND_TERM});
        tx_data = state_q == SEND_HDR   ? ASCII_L :
                  state_q == SEND_TENS  ? tens_ascii(row_q) :
                  state_q == SEND_UNITS ? units_ascii(row_q) :
                  state_q == SEND_TERM  ? ASCII_LF : byte_q;
        case (state_q)
            IDLE:       if (start) begin
                            row_d   = row;
                            state_d = SEND_HDR;
                        end
            SEND_HDR:   if (tx_done) state_d = SEND_TENS;
            SEND_TENS:  if (tx_done) state_d = SEND_UNITS;
            SEND_UNITS: if (tx_done) state_d = FETCH;
            FETCH:      state_d = CAPTURE;
            CAPTURE:    begin
                            byte_d  = ram_data_in;
                            state_d = SEND_DATA;
                        end
            SEND_DATA:  if (tx_done) begin
                            if (idx_q == LAST_IDX) begin
                                state_d = SEND_TERM;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = FETCH;
                            end
                        end
            SEND_TERM:  if (tx_done) state_d = FINISH;
            FINISH:     begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end
            default:    state_d = IDLE;
        endcase
        addr_d = state_d == FETCH ? {row_d, idx_d} : addr_q;
    end

    // sequencer registers; the address only moves on entry to FETCH and holds otherwise
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_framebuffer_readback.sv
// tb_framebuffer_readback: scoreboard bench decoding the UART line against expected frames and RAM fetch order
module tb_framebuffer_readback;

    localparam int B  = 4;
    localparam int BS = 192;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [4:0]  row;
    logic [11:0] ram_address;
    logic        ram_clk_enable;
    logic [7:0]  ram_data;
    logic        busy, done, tx_out;

    logic        s_rst_n, s_start;
    logic [4:0]  s_row;
    logic [11:0] s_ram_address;
    logic        s_ram_en;
    logic [7:0]  s_ram_data;
    logic        s_busy, s_done, s_tx;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          rst_gen = 0;
    logic [4:0]  cur_row = 5'd0;
    int          fetch_cnt = 0;
    int          fetch_base = 0;
    int          done_cnt = 0;
    int          overlap_cnt = 0;

    always #5 clk = ~clk;

    framebuffer_readback #(.BAUD_TICKS_WIDTH(8), .BAUD_TICKS(B), .ROW_BYTES_LOG2(7)) dut (
        .clk_in(clk), .reset(rst_n), .start(start), .row(row),
        .ram_address(ram_address), .ram_clk_enable(ram_clk_enable), .ram_data_in(ram_data),
        .busy(busy), .done(done), .tx_out(tx_out)
    );

    framebuffer_readback #(.BAUD_TICKS_WIDTH(8), .BAUD_TICKS(BS), .ROW_BYTES_LOG2(7)) dut_slow (
        .clk_in(clk), .reset(s_rst_n), .start(s_start), .row(s_row),
        .ram_address(s_ram_address), .ram_clk_enable(s_ram_en), .ram_data_in(s_ram_data),
        .busy(s_busy), .done(s_done), .tx_out(s_tx)
    );

    // row 7 holds byte k = k; other rows get a row-dependent pattern so wrong-row reads show up
    function automatic logic [7:0] ram_val(input logic [11:0] a);
        logic [4:0] r;
        logic [6:0] k;
        r = a[11:7];
        k = a[6:0];
        return (r == 5'd7) ? {1'b0, k} : {1'b0, k} + {3'b000, r} * 8'd29 + 8'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (ram_clk_enable) ram_data <= ram_val(ram_address);
    always @(posedge clk) if (s_ram_en) s_ram_data <= ram_val(s_ram_address);

    always @(negedge clk) begin
        if (rst_n && ram_clk_enable) begin
            chk("ram_addr", 32'(ram_address), 32'({cur_row, 7'(fetch_cnt - fetch_base)}));
            fetch_cnt++;
        end
        if (done) done_cnt++;
        if (busy && done) overlap_cnt++;
    end

    initial begin : uart_mon
        int         g;
        logic [7:0] rx;
        logic       stop_ok;
        forever begin
            @(negedge clk);
            if (rst_n && tx_out == 1'b0) begin
                g = rst_gen;
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    rx[i] = tx_out;
                end
                repeat (B) @(negedge clk);
                stop_ok = tx_out;
                if (g == rst_gen && rst_n) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx);
                    end else begin
                        chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
                        chk("stop_bit", 32'(stop_ok), 32'd1);
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [4:0] r, input logic [7:0] tens, input logic [7:0] units);
        exp_q.push_back(8'h4C);
        exp_q.push_back(tens);
        exp_q.push_back(units);
        for (int k = 0; k < 128; k++) exp_q.push_back(ram_val({r, 7'(k)}));
        exp_q.push_back(8'h0A);
        cur_row    = r;
        fetch_base = fetch_cnt;
    endtask

    task automatic run_frame(input logic [4:0] r, input logic [7:0] tens, input logic [7:0] units,
                             input logic [4:0] pulse_row, input bit extra_start);
        int n, busy_gap, d0, o0, bad;
        push_frame(r, tens, units);
        d0 = done_cnt;
        o0 = overlap_cnt;
        @(negedge clk);
        start = 1'b1;
        row   = r;
        @(negedge clk);
        start = 1'b0;
        row   = 5'd0;
        chk("busy_rise", 32'(busy), 32'd1);
        n = 0;
        busy_gap = 0;
        while (!done && n < 20000) begin
            if (!busy) busy_gap++;
            start = extra_start && n == 500;
            row   = pulse_row;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", 32'(n < 20000), 32'd1);
        chk("busy_span", 32'(busy_gap), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("overlap", 32'(overlap_cnt - o0), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("fetch_count", 32'(fetch_cnt - fetch_base), 32'd128);
        bad = 0;
        repeat (300) begin
            if (busy || !tx_out) bad++;
            @(negedge clk);
        end
        chk("idle_after", 32'(bad), 32'd0);
    endtask

    task automatic slow_test();
        logic [7:0] sb[5];
        int         n, bad, gap;
        logic       eb;
        sb = '{8'h4C, 8'h30, 8'h35, 8'h92, 8'h93};
        @(negedge clk);
        s_rst_n = 1'b1;
        @(negedge clk);
        s_start = 1'b1;
        s_row   = 5'd5;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (s_tx && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("slow_start_bit", 32'(n < 2000), 32'd1);
        for (int j = 0; j < 5; j++) begin
            bad = 0;
            for (int b = 0; b < 10; b++) begin
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sb[j][b-1];
                for (int c = 0; c < BS; c++) begin
                    if (s_tx !== eb) bad++;
                    @(negedge clk);
                end
            end
            chk("bit_cells", 32'(bad), 32'd0);
            if (j < 4) begin
                gap = 0;
                while (s_tx && gap < 50) begin
                    gap++;
                    @(negedge clk);
                end
                chk("gap_le3", 32'(gap >= 1 && gap <= 3), 32'd1);
            end
        end
        s_rst_n = 1'b0;
    endtask

    initial begin : stim
        int n, bad;
        rst_n   = 1'b0;
        start   = 1'b0;
        row     = 5'd0;
        s_rst_n = 1'b0;
        s_start = 1'b0;
        s_row   = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_en", 32'(ram_clk_enable), 32'd0);
        chk("rst_ram_addr", 32'(ram_address), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (!tx_out || busy || ram_clk_enable) bad++;
        end
        chk("idle_no_start", 32'(bad), 32'd0);

        run_frame(5'd7, 8'h30, 8'h37, 5'd0, 1'b0);
        run_frame(5'd31, 8'h33, 8'h31, 5'd0, 1'b0);
        run_frame(5'd12, 8'h31, 8'h32, 5'd3, 1'b1);

        push_frame(5'd20, 8'h32, 8'h30);
        @(negedge clk);
        start = 1'b1;
        row   = 5'd20;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((fetch_cnt - fetch_base) < 41 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte40", 32'(n < 20000), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_out", 32'(tx_out), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_gen++;
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        run_frame(5'd0, 8'h30, 8'h30, 5'd0, 1'b0);

        slow_test();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/framebuffer_readback.md
Name: framebuffer_readback

Overview:
- Reads one 64-pixel row (128 bytes) back out of framebuffer RAM port A and transmits it over a UART TX line (8N1, LSB first).
- Framing: 'L', two ASCII decimal row digits, 128 raw bytes, '\n'.
- Reverse path of the control_module line-write path; used to verify framebuffer contents from the host.
- Sits beside control_module on the clk_root domain and shares RAM port A through a top-level mux selected by busy.

Parameters:
- BAUD_TICKS_WIDTH, 8, width of the bit-period counter.
- BAUD_TICKS, 192, clk_in cycles per UART bit; legal range 2 to 2^BAUD_TICKS_WIDTH-1.
- ROW_BYTES_LOG2, 7, log2 of bytes per row (128).

Ports:
- clk_in  input  1  system clock (clk_root).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- row  input  5  row index 0..31; captured on an accepted start.
- ram_address  output  12  byte address {row_q, byte_idx}.
- ram_clk_enable  output  1  RAM read strobe.
- ram_data_in  input  8  RAM read data; valid the cycle after ram_clk_enable.
- busy  output  1  high from an accepted start until the '\n' stop bit completes.
- done  output  1  one-cycle pulse after the last stop bit.
- tx_out  output  1  UART line; idle high.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx_out=1, busy=0, done=0, ram_clk_enable=0, ram_address=0, byte_idx=0, baud counter=0.
- Start acceptance:
  - start=1 in IDLE captures row into row_q; busy rises the next cycle.
  - start while busy is ignored; there is no queue.
  - row is don't-care after capture.
- Row digits: ASCII tens digit = "0"+row_q/10 and units digit = "0"+row_q%10, computed combinationally from row_q (0..31, so tens is 0..3).
- FSM states: IDLE, SEND_HDR, SEND_TENS, SEND_UNITS, FETCH, CAPTURE, SEND_DATA, SEND_TERM, FINISH.
  - IDLE -> SEND_HDR on an accepted start.
  - Each SEND_* state loads one byte into the uart_tx_byte sub-module and waits for its tx_done.
  - SEND_HDR (0x4C) -> SEND_TENS -> SEND_UNITS -> FETCH.
  - FETCH: ram_clk_enable=1 for exactly one cycle with ram_address={row_q, byte_idx}; -> CAPTURE.
  - CAPTURE: registers ram_data_in into the tx byte; -> SEND_DATA.
  - SEND_DATA on tx_done: if byte_idx==127 -> SEND_TERM; else byte_idx+1 and -> FETCH.
  - SEND_TERM (0x0A) on tx_done -> FINISH.
  - FINISH: done=1 for one cycle, busy=0, byte_idx=0; -> IDLE.
- ram_clk_enable is 0 in every state other than FETCH; ram_address holds its last value elsewhere.
- Byte ordering: addresses ascend 0..127 within the row; bytes go out in address order.
- UART (uart_tx_byte):
  - One start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly BAUD_TICKS cycles.
  - tx_done pulses in the final cycle of the stop bit.
  - The next byte's start bit begins at most 3 cycles after tx_done (the FETCH+CAPTURE gap for data bytes, 1 cycle for header bytes); tx_out stays 1 in the gap.
- Frame length: 132 bytes, 1320 bit periods.
- busy and done are never high in the same cycle.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronously); the partial frame is abandoned; the host detects it by the missing '\n'.
- Address width: byte_idx is ROW_BYTES_LOG2 bits; at 127 the design never increments it (no wrap into the next row).

Decomposition:
- Shared package constants: ASCII_L=8'h4C, ASCII_LF=8'h0A, ASCII_ZERO=8'h30, and the FSM state encoding (4-bit).
- Sub-module uart_tx_byte(clk_in, reset, load, data[7:0], tx_out, tx_busy, tx_done) carries the BAUD_TICKS parameters. It is also reusable by the debugger.

Test Plan:
- Reset check: hold reset=0 -> tx_out=1, busy=0, ram_clk_enable=0; release with no start -> line stays 1 for 10000 cycles.
- Row 7 frame: RAM preloaded with byte k = k for row 7; BAUD_TICKS=4; start with row=7.
  - UART monitor decodes 0x4C, 0x30, 0x37, 0x00..0x7F, 0x0A.
  - First RAM address 0x380, last address 0x3FF.
  - done pulses once; busy spans the whole frame.
- Row 31 frame: start with row=31 -> digits 0x33, 0x31; addresses 0xF80..0xFFF; no access outside that range.
- Start while busy: start pulse with row=3 while a row-12 frame is in progress -> frame continues with 0x31, 0x32 digits and row-12 data; no second frame follows.
- Reset mid-frame: reset asserted during data byte 40 -> tx_out=1 and busy=0 in the same cycle; a new start with row=0 after release produces a full, correct 132-byte frame.
- Bit timing: BAUD_TICKS=192 -> every bit is measured at exactly 192 cycles; the inter-byte idle gap is 3 cycles or fewer.
